// File: rtl/button_conditioner.sv
// button_conditioner: debounces active-low keys into clean levels and one-cycle press/release pulses.
// Optional macro BUTTON_AUTOREPEAT_EN adds periodic press_pulse re-firing while a key is held.
module button_conditioner #(
    parameter int BUTTON_COUNT  = 4,
    parameter int COUNTER_WIDTH = 20,
    parameter int STABLE_COUNT  = 500000,
    parameter int REPEAT_COUNT  = 5000000
) (
    input  logic                    fast_clock,
    input  logic                    reset,
    input  logic [BUTTON_COUNT-1:0] raw_buttons,
    output logic [BUTTON_COUNT-1:0] level,
    output logic [BUTTON_COUNT-1:0] press_pulse,
    output logic [BUTTON_COUNT-1:0] release_pulse,
    output logic [BUTTON_COUNT-1:0] busy
);
    typedef enum logic [1:0] {RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_t;
    localparam logic [COUNTER_WIDTH-1:0] STABLE = COUNTER_WIDTH'(STABLE_COUNT);
    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);
    logic [BUTTON_COUNT-1:0] sync1, sync2;
    // two-flop synchronizer; flops rest at the released (high) key level
    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw_buttons;
            sync2 <= sync1;
        end
    end
    genvar i;
    for (i = 0; i < BUTTON_COUNT; i++) begin : g_lane
        logic sampled;
        state_t state, state_next;
        logic [COUNTER_WIDTH-1:0] cnt, cnt_next;
        logic press_q, release_q, press_next, release_next;
        logic lane_level, lane_busy;
        assign sampled = ~sync2[i];
`ifdef BUTTON_AUTOREPEAT_EN
        localparam logic [COUNTER_WIDTH+3:0] REPEAT = (COUNTER_WIDTH+4)'(REPEAT_COUNT);
        localparam logic [COUNTER_WIDTH+3:0] RONE = (COUNTER_WIDTH+4)'(1);
        logic [COUNTER_WIDTH+3:0] rep, rep_next;
        logic rep_hit;
        assign rep_hit = (state == PRESSED) && sampled && (rep + RONE == REPEAT);
`endif
        // lane state, stability counter and registered pulses
        always_ff @(posedge fast_clock or posedge reset) begin
            if (reset) begin
                state     <= RELEASED;
                cnt       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
                rep       <= '0;
`endif
            end else begin
                state     <= state_next;
                cnt       <= cnt_next;
                press_q   <= press_next;
                release_q <= release_next;
`ifdef BUTTON_AUTOREPEAT_EN
                rep       <= rep_next;
`endif
            end
        end
        // next state: a disagreeing level must persist STABLE_COUNT counted cycles to be accepted
        always_comb begin
            state_next   = state;
            cnt_next     = cnt;
            press_next   = 1'b0;
            release_next = 1'b0;
            case (state)
                RELEASED: begin
                    if (sampled) begin
                        state_next = WAIT_PRESS;
                        cnt_next   = ONE;
                    end
                end
                WAIT_PRESS: begin
                    if (!sampled) begin
                        state_next = RELEASED;
                        cnt_next   = '0;
                    end else if (cnt == STABLE) begin
                        state_next = PRESSED;
                        cnt_next   = '0;
                        press_next = 1'b1;
                    end else begin
                        cnt_next = cnt + ONE;
                    end
                end
                PRESSED: begin
                    if (!sampled) begin
                        state_next = WAIT_RELEASE;
                        cnt_next   = ONE;
                    end
                end
                WAIT_RELEASE: begin
                    if (sampled) begin
                        state_next = PRESSED;
                        cnt_next   = '0;
                    end else if (cnt == STABLE) begin
                        state_next   = RELEASED;
                        cnt_next     = '0;
                        release_next = 1'b1;
                    end else begin
                        cnt_next = cnt + ONE;
                    end
                end
                default: begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end
            endcase
`ifdef BUTTON_AUTOREPEAT_EN
            rep_next   = ((state == PRESSED) && sampled && !rep_hit) ? rep + RONE : '0;
            press_next = press_next | rep_hit;
`endif
        end
        // per-state outputs decoded from the registered state
        always_comb begin
            lane_level = (state == PRESSED) || (state == WAIT_RELEASE);
            lane_busy  = (state == WAIT_PRESS) || (state == WAIT_RELEASE);
        end
        assign level[i]         = lane_level;
        assign busy[i]          = lane_busy;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: random and directed checks of two instances (STABLE_COUNT 4 and 1) against a run-length model.
module tb_button_conditioner;
    localparam int S0 = 4;
    localparam int S1 = 1;
    localparam int RPT = 10;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    logic fast_clock = 1'b0;
    logic reset = 1'b1;
    logic [3:0] raw0 = '1, raw1 = '1;
    logic [3:0] level0, press0, release0, busy0;
    logic [3:0] level1, press1, release1, busy1;
    int tests = 0, fails = 0;
    logic [3:0] m_level [2];
    logic [3:0] m_press [2];
    logic [3:0] m_release [2];
    logic [3:0] m_busy [2];
    int m_run [2][4];
    int m_held [2][4];
    logic [3:0] hq0 [$];
    logic [3:0] hq1 [$];

    always #5 fast_clock = ~fast_clock;

    button_conditioner #(.BUTTON_COUNT(4), .COUNTER_WIDTH(20), .STABLE_COUNT(S0), .REPEAT_COUNT(RPT)) dut0 (
        .fast_clock(fast_clock), .reset(reset), .raw_buttons(raw0),
        .level(level0), .press_pulse(press0), .release_pulse(release0), .busy(busy0));
    button_conditioner #(.BUTTON_COUNT(4), .COUNTER_WIDTH(20), .STABLE_COUNT(S1), .REPEAT_COUNT(RPT)) dut1 (
        .fast_clock(fast_clock), .reset(reset), .raw_buttons(raw1),
        .level(level1), .press_pulse(press1), .release_pulse(release1), .busy(busy1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset;
        for (int d = 0; d < 2; d++) begin
            m_level[d] = '0;
            m_press[d] = '0;
            m_release[d] = '0;
            m_busy[d] = '0;
            for (int l = 0; l < 4; l++) begin
                m_run[d][l] = 0;
                m_held[d][l] = 0;
            end
        end
        hq0.delete();
        hq1.delete();
        repeat (2) begin
            hq0.push_back(4'hf);
            hq1.push_back(4'hf);
        end
    endtask

    // a level is accepted once the synchronised key disagrees with it for stable+1 consecutive edges
    task automatic model_lane(input int d, input logic [3:0] smp, input int stable);
        m_press[d] = '0;
        m_release[d] = '0;
        for (int l = 0; l < 4; l++) begin
            if (smp[l] != m_level[d][l]) begin
                m_run[d][l]++;
                m_held[d][l] = 0;
                if (m_run[d][l] == stable + 1) begin
                    m_level[d][l] = smp[l];
                    m_run[d][l] = 0;
                    if (smp[l]) m_press[d][l] = 1'b1;
                    else m_release[d][l] = 1'b1;
                end
            end else begin
                if (m_run[d][l] > 0) m_held[d][l] = 0;
                else if (AR && m_level[d][l]) begin
                    m_held[d][l]++;
                    if (m_held[d][l] == RPT) begin
                        m_press[d][l] = 1'b1;
                        m_held[d][l] = 0;
                    end
                end
                m_run[d][l] = 0;
            end
            m_busy[d][l] = m_run[d][l] != 0;
        end
    endtask

    task automatic model_step;
        logic [3:0] s0, s1;
        s0 = ~hq0[hq0.size() - 2];
        s1 = ~hq1[hq1.size() - 2];
        hq0.push_back(raw0);
        hq1.push_back(raw1);
        if (hq0.size() > 4) void'(hq0.pop_front());
        if (hq1.size() > 4) void'(hq1.pop_front());
        model_lane(0, s0, S0);
        model_lane(1, s1, S1);
    endtask

    task automatic check_all;
        chk("level0", {28'd0, level0}, {28'd0, m_level[0]});
        chk("press0", {28'd0, press0}, {28'd0, m_press[0]});
        chk("release0", {28'd0, release0}, {28'd0, m_release[0]});
        chk("busy0", {28'd0, busy0}, {28'd0, m_busy[0]});
        chk("level1", {28'd0, level1}, {28'd0, m_level[1]});
        chk("press1", {28'd0, press1}, {28'd0, m_press[1]});
        chk("release1", {28'd0, release1}, {28'd0, m_release[1]});
        chk("busy1", {28'd0, busy1}, {28'd0, m_busy[1]});
    endtask

    task automatic tick;
        @(posedge fast_clock);
        model_step();
        #1;
        check_all();
        @(negedge fast_clock);
    endtask

    // runs until dut0 lane pulses (press or release), bounded to 20 cycles; k=-1 if never seen
    task automatic wait_pulse(input bit rel, input int lane, output int k, output int nb);
        k = -1;
        nb = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (busy0[lane]) nb++;
            if ((rel ? release0[lane] : press0[lane]) === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge fast_clock);
        reset = 1'b0;
    endtask

    initial begin
        int k, nb, np, lv;
        model_reset();
        raw0 = 4'b0000;
        @(negedge fast_clock);
        chk("rst_level", {28'd0, level0}, 32'd0);
        chk("rst_press", {28'd0, press0}, 32'd0);
        chk("rst_busy", {28'd0, busy0}, 32'd0);
        check_all();
        reset = 1'b0;
        wait_pulse(1'b0, 0, k, nb);
        chk("rst_press_lat", k, 7);
        chk("rst_all_press", {28'd0, press0}, 32'hf);
        chk("rst_all_level", {28'd0, level0}, 32'hf);
        raw0 = 4'b1111;
        repeat (8) tick();

        raw0 = 4'b1101;
        wait_pulse(1'b0, 1, k, nb);
        chk("clean_press_lat", k, 7);
        chk("clean_busy_cycles", nb, 4);
        tick();
        chk("clean_level", {31'd0, level0[1]}, 32'd1);
        chk("clean_single_pulse", {31'd0, press0[1]}, 32'd0);
        raw0 = 4'b1111;
        wait_pulse(1'b1, 1, k, nb);
        chk("clean_release_lat", k, 7);
        tick();
        chk("clean_level_off", {31'd0, level0[1]}, 32'd0);

        np = 0;
        lv = 0;
        for (int i = 0; i < 20; i++) begin
            raw0[2] = ((i / 2) % 2) == 1;
            tick();
            np += press0[2] + release0[2];
            lv += level0[2];
        end
        raw0 = 4'b1111;
        repeat (8) begin
            tick();
            np += press0[2] + release0[2];
            lv += level0[2];
        end
        chk("bounce_pulses", np, 0);
        chk("bounce_level", lv, 0);

        raw0 = 4'b0110;
        wait_pulse(1'b0, 0, k, nb);
        chk("sim_press", {28'd0, press0}, 32'h9);
        raw0 = 4'b1111;
        repeat (10) tick();

        raw0 = 4'b1110;
        repeat (4) tick();
        chk("mid_busy", {31'd0, busy0[0]}, 32'd1);
        raw0 = 4'b1111;
        do_reset();
        np = 0;
        repeat (10) begin
            tick();
            np += press0[0] + release0[0];
        end
        chk("mid_reset_no_pulse", np, 0);

        raw0 = 4'b1110;
        wait_pulse(1'b0, 0, k, nb);
        np = (k > 0) ? 1 : 0;
        repeat (40) begin
            tick();
            np += press0[0];
        end
        chk("repeat_pulses", np, AR ? 5 : 1);
        raw0 = 4'b1111;
        repeat (10) tick();

        raw1 = 4'b1101;
        tick();
        raw1 = 4'b1111;
        np = 0;
        repeat (6) begin
            tick();
            np += press1[1];
        end
        chk("min_glitch", np, 0);
        raw1 = 4'b1101;
        k = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 2) raw1 = 4'b1111;
            if (press1[1] === 1'b1 && k < 0) k = i;
        end
        chk("min_press_lat", k, 4);
        repeat (6) tick();

        for (int c = 0; c < 600; c++) begin
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 9) == 0) raw0[l] = ~raw0[l];
                if ($urandom_range(0, 4) == 0) raw1[l] = ~raw1[l];
            end
            if ($urandom_range(0, 249) == 0) do_reset();
            else tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Per-button input conditioning stage that sits directly upstream of the processor core, driven by `fast_clock`. It turns raw, bouncing, active-low board keys into clean debounced levels and single-cycle press/release pulses. Those outputs drive the core's confirmation, continue and OS-request inputs. One instance serves all keys; every button lane is independent and identical.

## Interface
- `BUTTON_COUNT`, default 4: number of independent button lanes.
- `COUNTER_WIDTH`, default 20: width of each lane's stability counter.
- `STABLE_COUNT`, default 500000: consecutive agreeing cycles needed to accept a new level. Legal range is 1 to 2^COUNTER_WIDTH-1.
- `REPEAT_COUNT`, default 5000000: hold time before the first auto-repeat and the period between repeats. Used only with `BUTTON_AUTOREPEAT_EN`. Sized by `COUNTER_WIDTH+4`.
- `fast_clock`, in, 1: the single clock; all state is on its rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `raw_buttons`, in, BUTTON_COUNT: board keys, active-low, asynchronous to `fast_clock`.
- `level`, out, BUTTON_COUNT: debounced state, 1 = pressed.
- `press_pulse`, out, BUTTON_COUNT: one-cycle pulse on an accepted press (and on auto-repeat when enabled).
- `release_pulse`, out, BUTTON_COUNT: one-cycle pulse on an accepted release.
- `busy`, out, BUTTON_COUNT: lane is in a WAIT state and its counter is running.

## Operation
- **Synchronizer.** Each lane has a 2-flop synchronizer, then inversion: `sampled = ~sync2`.
- **Lane FSM.** Four states: RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE.
  - RELEASED: if `sampled`=1, go to WAIT_PRESS and load counter = 1.
  - WAIT_PRESS: if `sampled`=0, return to RELEASED and clear the counter (glitch rejected, no pulse). If counter == STABLE_COUNT, go to PRESSED and pulse `press_pulse`. Otherwise counter += 1.
  - PRESSED: if `sampled`=0, go to WAIT_RELEASE and load counter = 1.
  - WAIT_RELEASE: mirror of WAIT_PRESS. Success gives RELEASED plus `release_pulse`. A glitch returns to PRESSED.
- **Outputs per state.**
  - `level` = 1 in PRESSED and WAIT_RELEASE, 0 otherwise.
  - `busy` = 1 in the WAIT states only.
- **Counter.** Unsigned; it never wraps because the compare fires first. With STABLE_COUNT = 1, a level is accepted on the first cycle after entering WAIT.
- **Pulse exclusivity.** `press_pulse` and `release_pulse` are never high together on a lane. Each pulse lasts exactly one `fast_clock` cycle.
- **Multiple lanes.** Any number of lanes may pulse in the same cycle, with no priority between them.
- **Bounce handling.** Bounce of any pattern shorter than STABLE_COUNT cycles produces no pulse and no `level` change.

## Timing
- **Reset values.** All lanes RELEASED, counters 0, synchronizer flops 1 (key released). All outputs 0.
- **Reset mid-operation.** Asserting `reset` during a WAIT state or during a pulse clears everything immediately. The lost pulse is not replayed.
- **Latency.** A clean edge on `raw_buttons` reaches the outputs STABLE_COUNT+3 cycles later, at the rising edge where `level` changes and the pulse is asserted. The breakdown is 2 synchronizer cycles, 1 transition into WAIT, and STABLE_COUNT cycles of counting.
- **Outputs are registered.** No combinational path from `raw_buttons` to any output.
- **Downstream slow clock.** Consumers on a slower derived clock must stretch or latch the pulses. This block does no clock-domain crossing beyond its input synchronizer.

## Configuration
- Macro: `BUTTON_AUTOREPEAT_EN`.
- **Defined.** Each lane gets a repeat counter that clears on entry to PRESSED.
  - While the lane stays in PRESSED, `press_pulse` re-fires every REPEAT_COUNT cycles: the first repeat comes REPEAT_COUNT cycles after the accepted press.
  - Leaving PRESSED clears the repeat counter.
  - WAIT_RELEASE suspends repeats. A glitch back to PRESSED restarts the repeat count from 0.
- **Undefined.** No repeat logic exists. `press_pulse` fires exactly once per accepted press.

## Test plan
Benches use STABLE_COUNT=4 and REPEAT_COUNT=10.
- **Reset values:** `reset`=1 with `raw_buttons`=4'b0000 (keys held) → all outputs 0. After releasing reset, lane 0 pulses `press_pulse` at cycle 7 and `level`=4'b1111.
- **Clean press:** clean press on lane 1 → `busy[1]`=1 for 4 cycles, `press_pulse[1]` one cycle at edge+7, then `level[1]`=1. Release → `release_pulse[1]` at edge+7, then `level[1]`=0.
- **Bounce rejection:** lane 2 toggles every 2 cycles for 20 cycles, then holds released → no pulses, `level[2]` stays 0.
- **Simultaneous lanes, reset mid-count:** lanes 0 and 3 pressed in the same cycle → both `press_pulse` bits high in the same cycle. Press lane 0 again and assert `reset` at counter=2 → lane returns to RELEASED with no pulse.
- **Auto-repeat enabled:** with `BUTTON_AUTOREPEAT_EN` defined, hold lane 0 for 40 cycles past acceptance → `press_pulse[0]` at acceptance and at +10, +20, +30, +40. Without the macro → single pulse only.
- **Minimum stability:** STABLE_COUNT=1 build, 1-cycle glitch on lane 1 → no pulse. 2-cycle hold → `press_pulse[1]` at edge+4.
